lane_tick_scheduler: RTL and testbench
======================================

// Module: lane_tick_scheduler
// PURPOSE
//  Times vehicle-lane movement and shares one lane-shift datapath between all lanes. Sits downstream of the main-menu FSM.
//  Takes the latched level (0..3), the game-state code and the load pulse from the menu. Issues one shift request at a time.
//  Each request carries a lane index and a direction. Arbitration is round-robin.
// PARAMETERS
//  LANES        4      number of vehicle lanes (2..8)
//  LANE_W       2      width of lane index, >= clog2(LANES)
//  PRESCALE     50000  clock cycles per base tick (>=2)
//  PRE_W        16     prescaler width, 2^PRE_W >= PRESCALE
//  PERIOD0      16     lane-0 period in base ticks at level 0
//  PERIOD_STEP  4      period reduction per level; PERIOD0-3*PERIOD_STEP >= 1 required
//  PER_W        6      lane-counter width, holds PERIOD0+LANES-1
// PORTS
//  LS_CLOCK_50    in   1       system clock
//  LS_RESET       in   1       reset, synchronous, active-high
//  LS_NVL_IN      in   2       level from menu, sampled only on LS_LOAD
//  LS_LOAD        in   1       one-cycle pulse from menu: latch level, restart
//  LS_ESTADO_IN   in   3       menu state code; 3'b111 = game running
//  LS_PAUSE       in   1       1 = freeze timing
//  LS_SHIFT_ACK   in   1       shift datapath accepted current request
//  LS_SHIFT_REQ   out  1       request to shift lane LS_SHIFT_LANE
//  LS_SHIFT_LANE  out  LANE_W  lane being requested
//  LS_SHIFT_DIR   out  1       0 = right (even lanes), 1 = left (odd lanes)
//  LS_RUNNING     out  1       1 in RUN or REQ state
//  LS_OVF         out  1       sticky: lane expired while its request was pending
// BEHAVIOUR
//  Reset: all outputs 0. State=STOP, level=0, prescaler=0, pending=0, last_grant=LANES-1.
//    Each lane counter is set to period(i)-1.
//  period(i) = PERIOD0 - level*PERIOD_STEP + i.
//  active = (LS_ESTADO_IN==3'b111) && !LS_PAUSE.
//  Prescaler and lane counters advance only when state is RUN or REQ and active=1.
//  Base tick: one-cycle strobe when the prescaler is at PRESCALE-1. The prescaler wraps to 0 on the tick.
//  On each base tick, per lane:
//    - cnt==0: reload to period(i)-1 and set pending[i].
//    - if pending[i] was already 1 and is not cleared this cycle: set LS_OVF. No queueing.
//    - otherwise: decrement cnt.
//  FSM:
//    STOP -> RUN when active.
//    RUN  -> STOP when !active. Counters and pending are kept.
//    RUN  -> REQ when pending!=0. The winner is the first set bit after last_grant, searching upward with wrap.
//            LANE and DIR are registered and REQ=1 from the next cycle.
//    REQ: LANE and DIR are held stable until ACK is seen.
//         On ACK: clear pending[lane], set last_grant=lane, REQ=0.
//         Then go to RUN if active, else STOP.
//         Going inactive during REQ does not drop REQ.
//  Pending bit is cleared by ACK and set by a tick in the same cycle: result is set (new expiry), no OVF.
//  LS_LOAD (priority over everything except reset), effective next cycle:
//    - latch level=LS_NVL_IN, reload all counters, prescaler=0, pending=0, LS_OVF=0, REQ=0, state=STOP.
//    - An in-flight request is abandoned. The menu only pulses LOAD outside 3'b111.
//  Latency: from the tick that sets pending with the FSM in RUN, to REQ=1, is 2 cycles (decide, register).
// CONFIGURATION
//  LS_OVF_COUNT_EN defined:
//    - adds output LS_OVF_CNT [7:0].
//    - increments, saturating at 255, on each cycle LS_OVF would be set. Cleared by reset or LOAD.
//  LS_OVF_COUNT_EN not defined: no port, no counter. LS_OVF is unchanged.
// TESTING (PRESCALE=4, defaults otherwise)
//  1. LOAD with NVL=0, ESTADO=111, ACK tied high.
//     -> First REQ is lane 0, DIR=0, 2 cycles after base tick 16 (~cycle 66 after RUN entry).
//     -> Then lanes 1, 2, 3 at ticks 17, 18, 19.
//  2. LOAD with NVL=3.
//     -> Lane 0 requests every 4 ticks (16 cycles); lane 3 every 7 ticks. DIR=1 on lanes 1 and 3.
//  3. ACK low through tick 19 -> pending=4'b1111.
//     -> Grants in order 0,1,2,3 with one request per ACK. LANE is stable while REQ=1.
//  4. ACK held low past tick 32 -> LS_OVF=1 and stays 1. A later LOAD -> LS_OVF=0.
//     With LS_OVF_COUNT_EN defined, LS_OVF_CNT counts each overrun tick.
//  5. PAUSE=1 for 100 cycles mid-run -> no counter change. Request times shift by exactly 100 cycles.
//     ESTADO!=111 during REQ -> REQ is held until ACK, then state STOP.
//  6. LOAD asserted during REQ -> REQ=0 next cycle, pending=0.
//     RESET mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lane_tick_scheduler.sv
// lane_tick_scheduler
//   Paces the vehicle lanes and shares a single lane-shift datapath between
//   them. A prescaler makes a base tick; every lane counts base ticks down
//   from its own period and flags itself pending when it expires. Pending
//   lanes are granted round-robin, one shift request at a time.
//   Optional feature macro: LS_OVF_COUNT_EN adds LS_OVF_CNT, a saturating
//   count of overrun cycles.
module lane_tick_scheduler #(
    parameter int LANES       = 4,
    parameter int LANE_W      = 2,
    parameter int PRESCALE    = 50000,
    parameter int PRE_W       = 16,
    parameter int PERIOD0     = 16,
    parameter int PERIOD_STEP = 4,
    parameter int PER_W       = 6
) (
    input  logic              LS_CLOCK_50,
    input  logic              LS_RESET,
    input  logic [1:0]        LS_NVL_IN,
    input  logic              LS_LOAD,
    input  logic [2:0]        LS_ESTADO_IN,
    input  logic              LS_PAUSE,
    input  logic              LS_SHIFT_ACK,
    output logic              LS_SHIFT_REQ,
    output logic [LANE_W-1:0] LS_SHIFT_LANE,
    output logic              LS_SHIFT_DIR,
    output logic              LS_RUNNING,
`ifdef LS_OVF_COUNT_EN
    output logic [7:0]        LS_OVF_CNT,
`endif
    output logic              LS_OVF
);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_REQ} state_t;

    localparam logic [PER_W-1:0] CNT_ONE = PER_W'(1);
    localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);
    localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PRESCALE - 1);

    // Counter reload value: period(i)-1 for the given level.
    function automatic logic [PER_W-1:0] f_reload(input logic [1:0] lvl, input int idx);
        return PER_W'(PERIOD0 - int'(lvl) * PERIOD_STEP + idx - 1);
    endfunction

    // Lane that follows 'base' by 'step' positions, wrapping at LANES.
    function automatic int f_wrap(input int base, input int step);
        return (base + step) % LANES;
    endfunction

    state_t                        r_state;
    logic [1:0]                    r_level;
    logic [PRE_W-1:0]              r_pre;
    logic [LANES-1:0][PER_W-1:0]   r_cnt;
    logic [LANES-1:0]              r_pend;
    logic [LANE_W-1:0]             r_last;
    logic                          r_req;
    logic [LANE_W-1:0]             r_lane;
    logic                          r_dir;
    logic                          r_ovf;
`ifdef LS_OVF_COUNT_EN
    logic [7:0]                    r_ovf_cnt;
`endif

    logic                          w_active;
    logic                          w_adv;
    logic                          w_tick;
    logic [LANES-1:0]              w_clr;
    logic [LANES-1:0]              w_set;
    logic [LANES-1:0]              w_pend_nxt;
    logic                          w_ovf_hit;
    logic [LANE_W-1:0]             w_win;
    logic                          w_win_vld;

    assign w_active = (LS_ESTADO_IN == 3'b111) && !LS_PAUSE;
    assign w_adv    = (r_state != ST_STOP) && w_active;
    assign w_tick   = w_adv && (r_pre == PRE_TOP);

    // Pending bookkeeping: ACK clears the granted lane, an expiry sets it
    // (set wins); an expiry on a still-pending lane is an overrun.
    always_comb begin
        w_clr     = '0;
        w_set     = '0;
        w_ovf_hit = 1'b0;
        if (r_state == ST_REQ && LS_SHIFT_ACK)
            w_clr[r_lane] = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (w_tick && r_cnt[i] == '0) begin
                w_set[i] = 1'b1;
                if (r_pend[i] && !w_clr[i])
                    w_ovf_hit = 1'b1;
            end
        end
        w_pend_nxt = (r_pend & ~w_clr) | w_set;
    end

    // Round-robin pick: first pending lane strictly after the last grant.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        for (int k = 1; k <= LANES; k++) begin
            if (!w_win_vld && r_pend[f_wrap(int'(r_last), k)]) begin
                w_win     = LANE_W'(f_wrap(int'(r_last), k));
                w_win_vld = 1'b1;
            end
        end
    end

    // Timing datapath: level latch, prescaler, lane counters, pending, overrun.
    always_ff @(posedge LS_CLOCK_50) begin
        if (LS_RESET) begin
            r_level <= 2'd0;
            r_pre   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < LANES; i++)
                r_cnt[i] <= f_reload(2'd0, i);
`ifdef LS_OVF_COUNT_EN
            r_ovf_cnt <= 8'd0;
`endif
        end else if (LS_LOAD) begin
            r_level <= LS_NVL_IN;
            r_pre   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < LANES; i++)
                r_cnt[i] <= f_reload(LS_NVL_IN, i);
`ifdef LS_OVF_COUNT_EN
            r_ovf_cnt <= 8'd0;
`endif
        end else begin
            if (w_adv)
                r_pre <= w_tick ? '0 : r_pre + PRE_ONE;
            if (w_tick) begin
                for (int i = 0; i < LANES; i++)
                    r_cnt[i] <= (r_cnt[i] == '0) ? f_reload(r_level, i)
                                                 : r_cnt[i] - CNT_ONE;
            end
            r_pend <= w_pend_nxt;
            if (w_ovf_hit)
                r_ovf <= 1'b1;
`ifdef LS_OVF_COUNT_EN
            if (w_ovf_hit && r_ovf_cnt != 8'hFF)
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
`endif
        end
    end

    // Control FSM: run/stop tracking and the single outstanding shift request.
    always_ff @(posedge LS_CLOCK_50) begin
        if (LS_RESET) begin
            r_state <= ST_STOP;
            r_req   <= 1'b0;
            r_lane  <= '0;
            r_dir   <= 1'b0;
            r_last  <= LANE_W'(LANES - 1);
        end else if (LS_LOAD) begin
            r_state <= ST_STOP;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    if (w_active)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!w_active) begin
                        r_state <= ST_STOP;
                    end else if (w_win_vld) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_lane  <= w_win;
                        r_dir   <= w_win[0];
                    end
                end
                ST_REQ: begin
                    // Request is held even if the game pauses; only ACK ends it.
                    if (LS_SHIFT_ACK) begin
                        r_last  <= r_lane;
                        r_req   <= 1'b0;
                        r_state <= w_active ? ST_RUN : ST_STOP;
                    end
                end
                default: r_state <= ST_STOP;
            endcase
        end
    end

    assign LS_SHIFT_REQ  = r_req;
    assign LS_SHIFT_LANE = r_lane;
    assign LS_SHIFT_DIR  = r_dir;
    assign LS_RUNNING    = (r_state != ST_STOP);
    assign LS_OVF        = r_ovf;
`ifdef LS_OVF_COUNT_EN
    assign LS_OVF_CNT    = r_ovf_cnt;
`endif

endmodule

// File: tb/tb_lane_tick_scheduler.sv
// Bench for lane_tick_scheduler: directed phases plus random traffic, all
// compared every cycle against a tick-count reference model.
module tb_lane_tick_scheduler;
    localparam int LANES       = 4;
    localparam int LANE_W      = 2;
    localparam int PRESCALE    = 4;
    localparam int PRE_W       = 16;
    localparam int PERIOD0     = 16;
    localparam int PERIOD_STEP = 4;
    localparam int PER_W       = 6;

    logic              clk = 1'b0;
    logic              rst, load, pause, ack;
    logic [1:0]        nvl;
    logic [2:0]        estado;
    logic              req, dir, running, ovf;
    logic [LANE_W-1:0] lane;
`ifdef LS_OVF_COUNT_EN
    logic [7:0]        ovf_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // reference model state (abstract: ticks since restart, not per-lane counters)
    int               m_level, m_ticks, m_phase, m_mode; // mode 0 stop, 1 run, 2 req
    int               m_last, m_req, m_lane, m_dir, m_ovf, m_ovfcnt;
    logic [LANES-1:0] m_pend;

    lane_tick_scheduler #(
        .LANES(LANES), .LANE_W(LANE_W), .PRESCALE(PRESCALE), .PRE_W(PRE_W),
        .PERIOD0(PERIOD0), .PERIOD_STEP(PERIOD_STEP), .PER_W(PER_W)
    ) dut (
        .LS_CLOCK_50  (clk),
        .LS_RESET     (rst),
        .LS_NVL_IN    (nvl),
        .LS_LOAD      (load),
        .LS_ESTADO_IN (estado),
        .LS_PAUSE     (pause),
        .LS_SHIFT_ACK (ack),
        .LS_SHIFT_REQ (req),
        .LS_SHIFT_LANE(lane),
        .LS_SHIFT_DIR (dir),
        .LS_RUNNING   (running),
`ifdef LS_OVF_COUNT_EN
        .LS_OVF_CNT   (ovf_cnt),
`endif
        .LS_OVF       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int period(input int lvl, input int i);
        return PERIOD0 - lvl * PERIOD_STEP + i;
    endfunction

    // One clock edge of the reference behaviour, from the inputs applied.
    task automatic model_step();
        logic [LANES-1:0] clr;
        int  act, tk, found;
        if (rst) begin
            m_level = 0; m_ticks = 0; m_phase = 0; m_mode = 0; m_pend = '0;
            m_last = LANES - 1; m_req = 0; m_lane = 0; m_dir = 0; m_ovf = 0; m_ovfcnt = 0;
            return;
        end
        if (load) begin
            m_level = int'(nvl); m_ticks = 0; m_phase = 0; m_mode = 0; m_pend = '0;
            m_req = 0; m_ovf = 0; m_ovfcnt = 0;
            return;
        end
        act = (estado == 3'b111 && !pause) ? 1 : 0;
        tk  = 0;
        if (m_mode != 0 && act == 1) begin
            if (m_phase == PRESCALE - 1) tk = 1;
            m_phase = (m_phase + 1) % PRESCALE;
        end
        clr = '0;
        if (m_mode == 2 && ack) clr[m_lane] = 1'b1;
        // FSM decision uses the pending set from before this edge
        case (m_mode)
            0: if (act == 1) m_mode = 1;
            1: begin
                if (act == 0) m_mode = 0;
                else if (m_pend != '0) begin
                    found = 0;
                    for (int k = 1; k <= LANES; k++) begin
                        int idx;
                        idx = (m_last + k) % LANES;
                        if (found == 0 && m_pend[idx]) begin
                            found = 1; m_lane = idx; m_dir = idx % 2;
                        end
                    end
                    m_req = 1; m_mode = 2;
                end
            end
            default: if (ack) begin
                m_last = m_lane; m_req = 0; m_mode = (act == 1) ? 1 : 0;
            end
        endcase
        if (tk == 1) begin
            int hit;
            hit = 0;
            m_ticks++;
            for (int i = 0; i < LANES; i++)
                if (m_ticks % period(m_level, i) == 0 && m_pend[i] && !clr[i]) hit = 1;
            m_pend = m_pend & ~clr;
            for (int i = 0; i < LANES; i++)
                if (m_ticks % period(m_level, i) == 0) m_pend[i] = 1'b1;
            if (hit == 1) begin
                m_ovf = 1;
                if (m_ovfcnt < 255) m_ovfcnt++;
            end
        end else begin
            m_pend = m_pend & ~clr;
        end
    endtask

    // Advance one cycle, update the model, compare just after the edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        chk("req", int'(req), m_req);
        chk("running", int'(running), (m_mode != 0) ? 1 : 0);
        chk("ovf", int'(ovf), m_ovf);
        if (m_req == 1) begin
            chk("lane", int'(lane), m_lane);
            chk("dir", int'(dir), m_dir);
        end
`ifdef LS_OVF_COUNT_EN
        chk("ovf_cnt", int'(ovf_cnt), m_ovfcnt);
`endif
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int n;
        rst = 1'b1; load = 1'b0; pause = 1'b0; ack = 1'b0; nvl = 2'd0; estado = 3'd0;
        run(3);
        chk("rst_req", int'(req), 0);
        chk("rst_lane", int'(lane), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst = 1'b0;

        // level 0, ACK tied high: first grant is lane 0, 66 edges after LOAD
        load = 1'b1; nvl = 2'd0; cyc();
        load = 1'b0; estado = 3'b111; ack = 1'b1;
        n = 0;
        while (!req && n < 200) begin cyc(); n++; end
        chk("first_req_latency", n, 66);
        chk("first_lane", int'(lane), 0);
        chk("first_dir", int'(dir), 0);
        run(300);

        // level 3
        estado = 3'd0; load = 1'b1; nvl = 2'd3; cyc();
        load = 1'b0; estado = 3'b111;
        run(400);

        // ACK held low: pending piles up, lane 0 overruns at tick 32
        estado = 3'd0; load = 1'b1; nvl = 2'd0; ack = 1'b0; cyc();
        load = 1'b0; estado = 3'b111;
        run(200);
        chk("ovf_set", int'(ovf), 1);
        ack = 1'b1; run(20);
        chk("ovf_sticky", int'(ovf), 1);
        estado = 3'd0; load = 1'b1; cyc();
        chk("ovf_cleared_by_load", int'(ovf), 0);
        load = 1'b0;

        // pause for 100 cycles mid-run, then drop game state during a request
        estado = 3'b111; run(120);
        pause = 1'b1; run(100);
        pause = 1'b0; ack = 1'b0;
        n = 0;
        while (!req && n < 300) begin cyc(); n++; end
        chk("req_before_estado_drop", int'(req), 1);
        estado = 3'd2; run(5);
        chk("req_held_inactive", int'(req), 1);
        ack = 1'b1; cyc();
        chk("stop_after_ack", int'(running), 0);

        // LOAD during an outstanding request abandons it
        estado = 3'b111; ack = 1'b0;
        n = 0;
        while (!req && n < 300) begin cyc(); n++; end
        chk("req_before_load", int'(req), 1);
        load = 1'b1; estado = 3'd0; cyc();
        chk("req_dropped_by_load", int'(req), 0);
        load = 1'b0; estado = 3'b111;

        // reset mid-run
        run(150);
        rst = 1'b1; cyc();
        chk("midrst_req", int'(req), 0);
        chk("midrst_running", int'(running), 0);
        chk("midrst_lane", int'(lane), 0);
        rst = 1'b0;

        // random traffic
        for (int i = 0; i < 5000; i++) begin
            ack    = ($urandom % 3) != 0;
            if ($urandom % 64 == 0) pause = ~pause;
            estado = ($urandom % 40 == 0) ? 3'($urandom % 8) : 3'b111;
            load   = ($urandom % 400 == 0);
            nvl    = 2'($urandom % 4);
            rst    = ($urandom % 2500 == 0);
            cyc();
        end
        rst = 1'b0; load = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
